btn_mem_writer: RTL and testbench
=================================

Name: btn_mem_writer

Overview:
- Parametrised successor to the fixed button-to-memory write decoder on the ARMv4 board.
- Synchronises and debounces N active-low push buttons, then looks up a per-button (address, data) pair and issues exactly one handshaked write per press to the data-memory write port.
- An optional auto-increment mode steps each button's target address on successive presses.
- Sits between the board button pins and the data memory's external write port.

Parameters:
- N_BTN, 3, number of active-low buttons.
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- DEBOUNCE_CYC, 4, stable-press cycles required before a write; minimum 1.
- ADDR_TABLE, {8'd0, 8'd0, 8'd6}, packed N_BTN*ADDR_W base addresses; slice i belongs to btn[i].
- DATA_TABLE, {8'd0, 8'd8, 8'd9}, packed N_BTN*DATA_W write data; slice i belongs to btn[i].
- AUTO_INC, 0, 1 = add the per-button offset to the base address and advance it after each write.
- WRAP_LEN, 4, number of offset steps before the offset wraps to 0; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- btn  in  N_BTN  raw buttons, 0 = pressed.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  DATA_W  write data.
- busy  out  1  FSM not in IDLE.
- wr_count  out  8  number of accepted writes, wraps at 255->0.

Behaviour:
- Reset: single clock, synchronous active-low reset (rst_n sampled on the rising edge of clk). While rst_n=0 at a rising edge, all state clears and the FSM goes to IDLE. Outputs after reset: mem_we=0, mem_addr=0, mem_data=0, busy=0, wr_count=0. All per-button offsets, synchroniser flops (reset to 1, i.e. released), and the debounce counter also clear.
- Reset mid-operation: any state returns to IDLE and mem_we drops at that edge. The in-flight write is not counted.
- Input conditioning: btn passes through a 2-flop synchroniser. pressed = ~btn_sync.
- FSM states: IDLE, DEBOUNCE, WRITE, RELEASE. All outputs are registered or Moore-derived.
- IDLE:
  - If pressed != 0, capture sel = lowest pressed index, clear cnt, go to DEBOUNCE.
- DEBOUNCE:
  - If pressed[sel]=0, go to IDLE (glitch rejected, no write).
  - Else if cnt==DEBOUNCE_CYC-1, go to WRITE. Else cnt++.
- WRITE:
  - mem_we=1.
  - mem_addr = ADDR_TABLE[sel] + (AUTO_INC ? offset[sel] : 0), modulo 2^ADDR_W.
  - mem_data = DATA_TABLE[sel].
  - Address and data are held stable until mem_ready=1 is sampled.
  - On that edge: mem_we drops, wr_count++, and if AUTO_INC, offset[sel] = (offset[sel]==WRAP_LEN-1) ? 0 : offset[sel]+1. Go to RELEASE.
  - Button release during WRITE does not cancel the write.
- RELEASE:
  - Stay until pressed==0 is sampled, then go to IDLE. This guarantees one write per press.
- Latency: with btn low from edge k and mem_ready tied high, mem_we is high exactly after edge k+2+DEBOUNCE_CYC, for one cycle.
- Simultaneous presses: the lowest index wins. Other buttons are ignored until all buttons are released.
- mem_ready is ignored whenever mem_we=0.
- In IDLE, DEBOUNCE and RELEASE, mem_addr and mem_data hold their last driven values. The reset values (0) hold until the first write.
- busy=1 in DEBOUNCE, WRITE and RELEASE.

Decomposition:
- Package btn_mem_writer_pkg holds:
  - state_t enum {IDLE, DEBOUNCE, WRITE, RELEASE}.
  - The default table constants.
- Sub-module btn_sync: parametrised-width 2-flop synchroniser with synchronous active-low reset to all-ones.
- FSM, debounce counter, offset registers and output registers stay in btn_mem_writer.

Test Plan:
- Defaults, mem_ready=1: btn=3'b110 held 20 cycles -> single mem_we pulse after edge k+6, addr=6, data=9; wr_count=1; no second write until release.
- btn=3'b101 held, then released, then pressed again -> two writes of addr=0, data=8; wr_count=2.
- btn[0] low for 2 cycles only (DEBOUNCE_CYC=4) -> no mem_we; FSM returns to IDLE; busy pulses only.
- btn=3'b100 (btn[0] and btn[1] pressed together) -> write addr=6, data=9 only. Releasing btn[0] while btn[1] is still held gives no further write.
- mem_ready held 0 for 5 cycles in WRITE -> mem_we, addr and data stable all 5 cycles; write accepted on the first mem_ready=1; then rst_n=0 while in a later WRITE -> mem_we=0 after that edge, wr_count=0.
- AUTO_INC=1, WRAP_LEN=4: five presses of btn[0] -> addresses 6, 7, 8, 9, 6 (offset wrap verified).

Source files
------------

// File: rtl/btn_mem_writer_pkg.sv
// Shared types and default tables for the button-to-memory write decoder.
package btn_mem_writer_pkg;

  // Controller states: wait for a press, qualify it, issue the write, wait for release.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    WRITE    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Default per-button tables; slice i (LSB first) belongs to btn[i].
  localparam logic [23:0] DEF_ADDR_TABLE = {8'd0, 8'd0, 8'd6};
  localparam logic [23:0] DEF_DATA_TABLE = {8'd0, 8'd8, 8'd9};

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int width_of(input int v);
    if (v <= 1) begin
      return 1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/btn_mem_writer_sync.sv
// Two-flop synchroniser for asynchronous active-low button pins.
// Reset value is all-ones so every button reads as released.
module btn_sync
  import btn_mem_writer_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the raw pins; reset releases all buttons.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= {W{1'b1}};
      sync_q <= {W{1'b1}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/btn_mem_writer.sv
// Debounces N active-low buttons and issues one handshaked memory write
// per press, using a per-button (address, data) table. With AUTO_INC set,
// each button's address steps through WRAP_LEN consecutive locations.
module btn_mem_writer
  import btn_mem_writer_pkg::*;
#(
  parameter int                      N_BTN        = 3,
  parameter int                      ADDR_W       = 8,
  parameter int                      DATA_W       = 8,
  parameter int                      DEBOUNCE_CYC = 4,
  parameter logic [N_BTN*ADDR_W-1:0] ADDR_TABLE   = DEF_ADDR_TABLE,
  parameter logic [N_BTN*DATA_W-1:0] DATA_TABLE   = DEF_DATA_TABLE,
  parameter bit                      AUTO_INC     = 1'b0,
  parameter int                      WRAP_LEN     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BTN-1:0]  btn,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              busy,
  output logic [7:0]        wr_count
);

  localparam int SEL_W = width_of(N_BTN);
  localparam int CNT_W = width_of(DEBOUNCE_CYC);
  localparam int OFF_W = width_of(WRAP_LEN);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(WRAP_LEN - 1);

  // Conditioned button view
  logic [N_BTN-1:0]  btn_sync_s;
  logic [N_BTN-1:0]  pressed_s;
  logic              any_pressed_s;
  logic [SEL_W-1:0]  low_idx_s;

  // Table lookup and address arithmetic
  logic [ADDR_W-1:0] base_addr_s;
  logic [DATA_W-1:0] wr_data_s;
  logic [OFF_W-1:0]  cur_off_s;
  logic [OFF_W-1:0]  next_off_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // State registers and their next-state values
  state_t            state_q,    state_d;
  logic [SEL_W-1:0]  sel_q,      sel_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [OFF_W-1:0]  offset_q [N_BTN];
  logic [OFF_W-1:0]  offset_d [N_BTN];
  logic              mem_we_q,   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              busy_q,     busy_d;
  logic [7:0]        wr_count_q, wr_count_d;

  btn_sync #(
    .W (N_BTN)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn),
    .q_o   (btn_sync_s)
  );

  assign pressed_s     = ~btn_sync_s;
  assign any_pressed_s = |pressed_s;

  // Priority pick of the lowest-numbered pressed button.
  always_comb begin
    low_idx_s = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      low_idx_s = pressed_s[i] ? SEL_W'(i) : low_idx_s;
    end
  end

  // Table slices and the offset step for the selected button.
  always_comb begin
    base_addr_s = ADDR_TABLE[int'(sel_q)*ADDR_W +: ADDR_W];
    wr_data_s   = DATA_TABLE[int'(sel_q)*DATA_W +: DATA_W];
    cur_off_s   = offset_q[sel_q];
    if (cur_off_s == OFF_LAST) begin
      next_off_s = '0;
    end else begin
      next_off_s = cur_off_s + OFF_W'(1);
    end
    if (AUTO_INC) begin
      wr_addr_s = base_addr_s + ADDR_W'(cur_off_s);
    end else begin
      wr_addr_s = base_addr_s;
    end
  end

  // Controller next-state logic; outputs are loaded on the transitions
  // so that everything visible on the ports comes straight from flops.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    wr_count_d = wr_count_q;

    case (state_q)
      IDLE: begin
        if (any_pressed_s) begin
          sel_d   = low_idx_s;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end else begin
          state_d = IDLE;
        end
      end

      DEBOUNCE: begin
        if (!pressed_s[sel_q]) begin
          // Press did not last long enough: treat it as a glitch.
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = WRITE;
          mem_we_d   = 1'b1;
          mem_addr_d = wr_addr_s;
          mem_data_d = wr_data_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        // Address and data stay frozen until the memory accepts;
        // releasing the button here does not cancel the write.
        if (mem_ready) begin
          mem_we_d   = 1'b0;
          wr_count_d = wr_count_q + 8'd1;
          if (AUTO_INC) begin
            offset_d[sel_q] = next_off_s;
          end else begin
            offset_d = offset_q;
          end
          state_d = RELEASE;
        end else begin
          state_d = WRITE;
        end
      end

      RELEASE: begin
        // Every button must be released before a new press is looked at.
        if (!any_pressed_s) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end

      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      wr_count_q <= 8'd0;
      for (int i = 0; i < N_BTN; i++) begin
        offset_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      wr_count_q <= wr_count_d;
      offset_q   <= offset_d;
    end
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign busy     = busy_q;
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_btn_mem_writer.sv
// Bench for btn_mem_writer: one instance with fixed addresses and one with
// auto-increment, both fed the same button and handshake stimulus.
module tb_btn_mem_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b111;
  logic       mem_ready = 1'b0;

  logic       we0, we1, busy0, busy1;
  logic [7:0] addr0, addr1, data0, data1, wrc0, wrc1;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  // Reference: per-button base address and data, write count, offsets.
  int BASE [3] = '{6, 0, 0};
  int DAT  [3] = '{9, 8, 0};
  int cnt_m = 0;
  int off_m [3] = '{0, 0, 0};

  logic [7:0] q_addr0[$], q_data0[$], q_addr1[$], q_data1[$];
  logic [7:0] e_addr0[$], e_data0[$], e_addr1[$], e_data1[$];

  btn_mem_writer #(.AUTO_INC(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .mem_ready(mem_ready),
    .mem_we(we0), .mem_addr(addr0), .mem_data(data0), .busy(busy0), .wr_count(wrc0)
  );

  btn_mem_writer #(.AUTO_INC(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .btn(btn), .mem_ready(mem_ready),
    .mem_we(we1), .mem_addr(addr1), .mem_data(data1), .busy(busy1), .wr_count(wrc1)
  );

  always #5 clk = ~clk;

  // Record every write the memory will accept at the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && mem_ready) begin
      if (we0) begin q_addr0.push_back(addr0); q_data0.push_back(data0); end
      if (we1) begin q_addr1.push_back(addr1); q_data1.push_back(data1); end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic int lowest(input logic [2:0] pat);
    for (int i = 0; i < 3; i++) if (pat[i] == 1'b0) return i;
    return 0;
  endfunction

  function automatic void model_write(input int sel);
    e_addr0.push_back(8'(BASE[sel]));
    e_data0.push_back(8'(DAT[sel]));
    e_addr1.push_back(8'((BASE[sel] + off_m[sel]) % 256));
    e_data1.push_back(8'(DAT[sel]));
    off_m[sel] = (off_m[sel] + 1) % 4;
    cnt_m = (cnt_m + 1) % 256;
  endfunction

  function automatic void model_reset();
    cnt_m = 0;
    for (int i = 0; i < 3; i++) off_m[i] = 0;
  endfunction

  task automatic clear_q();
    q_addr0.delete(); q_data0.delete(); q_addr1.delete(); q_data1.delete();
    e_addr0.delete(); e_data0.delete(); e_addr1.delete(); e_data1.delete();
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Let the buttons' release propagate and wait for both controllers to idle.
  task automatic settle(output bit ok);
    int n;
    hold(4);
    n = 0;
    while ((busy0 || busy1) && n < 300) begin tick(); n++; end
    ok = !(busy0 || busy1);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 3'b111; mem_ready = 1'b0;
    hold(3);
    checks++; if (we0 !== 1'b0)    begin errors++; $display("FAIL reset_we0 got %0d exp 0", we0); end
    checks++; if (addr0 !== 8'd0)  begin errors++; $display("FAIL reset_addr0 got %0d exp 0", addr0); end
    checks++; if (data0 !== 8'd0)  begin errors++; $display("FAIL reset_data0 got %0d exp 0", data0); end
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL reset_busy0 got %0d exp 0", busy0); end
    checks++; if (wrc0 !== 8'd0)   begin errors++; $display("FAIL reset_wrc0 got %0d exp 0", wrc0); end
    checks++; if (we1 !== 1'b0)    begin errors++; $display("FAIL reset_we1 got %0d exp 0", we1); end
    checks++; if (addr1 !== 8'd0)  begin errors++; $display("FAIL reset_addr1 got %0d exp 0", addr1); end
    checks++; if (wrc1 !== 8'd0)   begin errors++; $display("FAIL reset_wrc1 got %0d exp 0", wrc1); end
    rst_n = 1'b1;
    model_reset();
    hold(3);
    checks++; if (busy0 !== 1'b0)  begin errors++; $display("FAIL post_reset_busy got %0d exp 0", busy0); end
  endtask

  task automatic test_latency();
    bit ok;
    clear_q();
    mem_ready = 1'b1;
    btn = 3'b110;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if (we0 !== 1'(i == 7)) begin errors++; $display("FAIL latency_we edge+%0d got %0d exp %0d", i - 1, we0, (i == 7)); end
      if (i == 7) begin
        checks++; if (addr0 !== 8'd6) begin errors++; $display("FAIL latency_addr got %0d exp 6", addr0); end
        checks++; if (data0 !== 8'd9) begin errors++; $display("FAIL latency_data got %0d exp 9", data0); end
        checks++; if (addr1 !== 8'd6) begin errors++; $display("FAIL latency_addr_auto got %0d exp 6", addr1); end
        model_write(0);
      end
    end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL latency_count got %0d exp %0d", wrc0, cnt_m); end
    checks++; if (busy0 !== 1'b1)     begin errors++; $display("FAIL latency_busy_held got %0d exp 1", busy0); end
    btn = 3'b111;
    settle(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL latency_settle got %0d exp 1", ok); end
    checks++; if (q_addr0.size() != 1) begin errors++; $display("FAIL latency_nwrites got %0d exp 1", q_addr0.size()); end
  endtask

  task automatic test_repress();
    bit ok;
    clear_q();
    for (int p = 0; p < 2; p++) begin
      btn = 3'b101; hold(12);
      btn = 3'b111; settle(ok);
      model_write(1);
    end
    checks++; if (q_addr0.size() != 2) begin errors++; $display("FAIL repress_nwrites got %0d exp 2", q_addr0.size()); end
    for (int i = 0; i < q_addr0.size() && i < 2; i++) begin
      checks++; if (q_addr0[i] !== 8'd0) begin errors++; $display("FAIL repress_addr[%0d] got %0d exp 0", i, q_addr0[i]); end
      checks++; if (q_data0[i] !== 8'd8) begin errors++; $display("FAIL repress_data[%0d] got %0d exp 8", i, q_data0[i]); end
    end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL repress_count got %0d exp %0d", wrc0, cnt_m); end
  endtask

  task automatic test_glitch();
    bit ok, saw_we, saw_busy;
    clear_q();
    saw_we = 1'b0; saw_busy = 1'b0;
    btn = 3'b110;
    for (int i = 0; i < 2; i++) begin tick(); saw_we |= we0; saw_busy |= busy0; end
    btn = 3'b111;
    for (int i = 0; i < 12; i++) begin tick(); saw_we |= we0; saw_busy |= busy0; end
    checks++; if (saw_we !== 1'b0)   begin errors++; $display("FAIL glitch_we got %0d exp 0", saw_we); end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse got %0d exp 1", saw_busy); end
    checks++; if (busy0 !== 1'b0)    begin errors++; $display("FAIL glitch_idle got %0d exp 0", busy0); end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL glitch_count got %0d exp %0d", wrc0, cnt_m); end
    settle(ok);
  endtask

  task automatic test_simul();
    bit ok;
    clear_q();
    btn = 3'b100; hold(12);
    btn = 3'b101; hold(12);
    btn = 3'b111; settle(ok);
    model_write(0);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL simul_settle got %0d exp 1", ok); end
    checks++; if (q_addr0.size() != 1) begin errors++; $display("FAIL simul_nwrites got %0d exp 1", q_addr0.size()); end
    if (q_addr0.size() > 0) begin
      checks++; if (q_addr0[0] !== 8'd6) begin errors++; $display("FAIL simul_addr got %0d exp 6", q_addr0[0]); end
      checks++; if (q_data0[0] !== 8'd9) begin errors++; $display("FAIL simul_data got %0d exp 9", q_data0[0]); end
    end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL simul_count got %0d exp %0d", wrc0, cnt_m); end
  endtask

  task automatic test_stall();
    bit ok;
    int n;
    clear_q();
    mem_ready = 1'b0;
    btn = 3'b110;
    n = 0;
    while (!we0 && n < 30) begin tick(); n++; end
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL stall_we_rise got %0d exp 1", we0); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (we0 !== 1'b1)   begin errors++; $display("FAIL stall_we cyc %0d got %0d exp 1", i, we0); end
      checks++; if (addr0 !== 8'd6) begin errors++; $display("FAIL stall_addr cyc %0d got %0d exp 6", i, addr0); end
      checks++; if (data0 !== 8'd9) begin errors++; $display("FAIL stall_data cyc %0d got %0d exp 9", i, data0); end
    end
    mem_ready = 1'b1;
    tick();
    model_write(0);
    checks++; if (we0 !== 1'b0)       begin errors++; $display("FAIL stall_accept_we got %0d exp 0", we0); end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL stall_accept_count got %0d exp %0d", wrc0, cnt_m); end
    mem_ready = 1'b0;
    btn = 3'b111; settle(ok);
    // Second write is interrupted by reset while stalled.
    btn = 3'b110;
    n = 0;
    while (!we0 && n < 30) begin tick(); n++; end
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL stall2_we_rise got %0d exp 1", we0); end
    rst_n = 1'b0;
    tick();
    model_reset();
    checks++; if (we0 !== 1'b0)   begin errors++; $display("FAIL midreset_we got %0d exp 0", we0); end
    checks++; if (wrc0 !== 8'd0)  begin errors++; $display("FAIL midreset_count got %0d exp 0", wrc0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0d exp 0", busy0); end
    checks++; if (addr0 !== 8'd0) begin errors++; $display("FAIL midreset_addr got %0d exp 0", addr0); end
    rst_n = 1'b1;
    btn = 3'b111;
    mem_ready = 1'b1;
    settle(ok);
  endtask

  task automatic test_auto_inc();
    bit ok;
    int exp_a [5] = '{6, 7, 8, 9, 6};
    clear_q();
    mem_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      btn = 3'b110; hold(8);
      btn = 3'b111; settle(ok);
      model_write(0);
    end
    checks++; if (q_addr1.size() != 5) begin errors++; $display("FAIL auto_nwrites got %0d exp 5", q_addr1.size()); end
    for (int i = 0; i < q_addr1.size() && i < 5; i++) begin
      checks++; if (q_addr1[i] !== 8'(exp_a[i])) begin errors++; $display("FAIL auto_addr[%0d] got %0d exp %0d", i, q_addr1[i], exp_a[i]); end
      checks++; if (q_data1[i] !== 8'd9) begin errors++; $display("FAIL auto_data[%0d] got %0d exp 9", i, q_data1[i]); end
      checks++; if (q_addr0[i] !== 8'd6) begin errors++; $display("FAIL fixed_addr[%0d] got %0d exp 6", i, q_addr0[i]); end
    end
    checks++; if (wrc1 !== 8'(cnt_m)) begin errors++; $display("FAIL auto_count got %0d exp %0d", wrc1, cnt_m); end
  endtask

  task automatic test_random();
    bit ok;
    logic [2:0] pat;
    int h;
    bit long_p;
    clear_q();
    rand_ready = 1'b1;
    for (int it = 0; it < 30; it++) begin
      pat = 3'($urandom_range(0, 6));
      long_p = ($urandom_range(0, 2) != 0);
      h = long_p ? int'($urandom_range(6, 15)) : int'($urandom_range(1, 3));
      btn = pat; hold(h);
      btn = 3'b111; settle(ok);
      if (long_p) model_write(lowest(pat));
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_settle it %0d got %0d exp 1", it, ok); end
    end
    rand_ready = 1'b0;
    mem_ready = 1'b1;
    checks++; if (q_addr0.size() != e_addr0.size()) begin errors++; $display("FAIL rand_nwrites0 got %0d exp %0d", q_addr0.size(), e_addr0.size()); end
    checks++; if (q_addr1.size() != e_addr1.size()) begin errors++; $display("FAIL rand_nwrites1 got %0d exp %0d", q_addr1.size(), e_addr1.size()); end
    for (int i = 0; i < q_addr0.size() && i < e_addr0.size(); i++) begin
      checks++; if (q_addr0[i] !== e_addr0[i]) begin errors++; $display("FAIL rand_addr0[%0d] got %0d exp %0d", i, q_addr0[i], e_addr0[i]); end
      checks++; if (q_data0[i] !== e_data0[i]) begin errors++; $display("FAIL rand_data0[%0d] got %0d exp %0d", i, q_data0[i], e_data0[i]); end
    end
    for (int i = 0; i < q_addr1.size() && i < e_addr1.size(); i++) begin
      checks++; if (q_addr1[i] !== e_addr1[i]) begin errors++; $display("FAIL rand_addr1[%0d] got %0d exp %0d", i, q_addr1[i], e_addr1[i]); end
      checks++; if (q_data1[i] !== e_data1[i]) begin errors++; $display("FAIL rand_data1[%0d] got %0d exp %0d", i, q_data1[i], e_data1[i]); end
    end
    checks++; if (wrc0 !== 8'(cnt_m)) begin errors++; $display("FAIL rand_count0 got %0d exp %0d", wrc0, cnt_m); end
    checks++; if (wrc1 !== 8'(cnt_m)) begin errors++; $display("FAIL rand_count1 got %0d exp %0d", wrc1, cnt_m); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_repress();
    test_glitch();
    test_simul();
    test_stall();
    test_auto_inc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
